// File: rtl/calc_max_timing.sv
// Per-phase maximum of five axis timing vectors, plus the sum of those maxima.
// Optional macro AXIS_MASK_EN adds an axis_mask input that excludes axes from the maximum.
module calc_max_timing (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] timing_x  [0:3],
  input  logic [63:0] timing_y  [0:3],
  input  logic [63:0] timing_z  [0:3],
  input  logic [63:0] timing_e0 [0:3],
  input  logic [63:0] timing_e1 [0:3],
`ifdef AXIS_MASK_EN
  input  logic [4:0]  axis_mask,
`endif
  output logic [63:0] max_timing [0:3],
  output logic [65:0] total_time,
  output logic        busy,
  output logic        finish
);

  typedef enum logic [1:0] {IDLE, SCAN, SUM, DONE} state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [2:0]  idx_reg;
  logic [63:0] acc_w [0:3];
  logic        start_scan;
  logic        scan_step;
  logic        commit;
  logic        axis_on;
  logic [65:0] sum_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Dropping start aborts from any state; only IDLE accepts a new run.
  always_comb begin
    state_next = state_reg;
    if (!start) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    state_next = SCAN;
        SCAN:    state_next = (idx_reg == 3'd4) ? SUM : SCAN;
        SUM:     state_next = DONE;
        DONE:    state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  assign start_scan = (state_reg == IDLE) && start;
  assign scan_step  = (state_reg == SCAN) && start;
  assign commit     = (state_reg == SUM)  && start;
  assign busy       = (state_reg == SCAN) || (state_reg == SUM);
  assign finish     = (state_reg == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          idx_reg <= 3'd0;
    else if (start_scan) idx_reg <= 3'd0;
    else if (scan_step)  idx_reg <= idx_reg + 3'd1;
    else if (!start)     idx_reg <= 3'd0;
  end

  always_comb begin
    axis_on = 1'b1;
`ifdef AXIS_MASK_EN
    case (idx_reg)
      3'd0:    axis_on = axis_mask[0];
      3'd1:    axis_on = axis_mask[1];
      3'd2:    axis_on = axis_mask[2];
      3'd3:    axis_on = axis_mask[3];
      3'd4:    axis_on = axis_mask[4];
      default: axis_on = 1'b0;
    endcase
`endif
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_phase
      logic [63:0] acc_reg;
      logic [63:0] res_reg;
      logic [63:0] sel;

      always_comb begin
        sel = '0;
        case (idx_reg)
          3'd0:    sel = timing_x[gi];
          3'd1:    sel = timing_y[gi];
          3'd2:    sel = timing_z[gi];
          3'd3:    sel = timing_e0[gi];
          3'd4:    sel = timing_e1[gi];
          default: sel = '0;
        endcase
        if (!axis_on) sel = '0;
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset)                          acc_reg <= '0;
        else if (start_scan)                 acc_reg <= '0;
        else if (scan_step && sel > acc_reg) acc_reg <= sel;
      end

      // Published result only changes on a completed SUM, so aborts keep the previous run.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)      res_reg <= '0;
        else if (commit) res_reg <= acc_reg;
      end

      assign max_timing[gi] = res_reg;
      assign acc_w[gi]      = acc_reg;
    end
  endgenerate

  assign sum_next = {2'b00, acc_w[0]} + {2'b00, acc_w[1]}
                  + {2'b00, acc_w[2]} + {2'b00, acc_w[3]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      total_time <= '0;
    else if (commit) total_time <= sum_next;
  end

endmodule

// File: tb/tb_calc_max_timing.sv
// Directed self-checking bench for calc_max_timing using immediate assertions.
module tb_calc_max_timing;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] timing_x  [0:3];
  logic [63:0] timing_y  [0:3];
  logic [63:0] timing_z  [0:3];
  logic [63:0] timing_e0 [0:3];
  logic [63:0] timing_e1 [0:3];
  logic [63:0] max_timing [0:3];
  logic [65:0] total_time;
  logic        busy;
  logic        finish;
`ifdef AXIS_MASK_EN
  logic [4:0]  axis_mask;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  calc_max_timing dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .timing_x(timing_x),
    .timing_y(timing_y),
    .timing_z(timing_z),
    .timing_e0(timing_e0),
    .timing_e1(timing_e1),
`ifdef AXIS_MASK_EN
    .axis_mask(axis_mask),
`endif
    .max_timing(max_timing),
    .total_time(total_time),
    .busy(busy),
    .finish(finish)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_max(input string tag, input logic [63:0] m0, input logic [63:0] m1,
                           input logic [63:0] m2, input logic [63:0] m3);
    check({tag, "_max0"}, {2'b00, max_timing[0]}, {2'b00, m0});
    check({tag, "_max1"}, {2'b00, max_timing[1]}, {2'b00, m1});
    check({tag, "_max2"}, {2'b00, max_timing[2]}, {2'b00, m2});
    check({tag, "_max3"}, {2'b00, max_timing[3]}, {2'b00, m3});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 4; k++) begin
      timing_x[k] = '0; timing_y[k] = '0; timing_z[k] = '0;
      timing_e0[k] = '0; timing_e1[k] = '0;
    end
  endtask

  // Assumes IDLE; raises start and steps 7 edges. Totals must hold prev until the 7th edge.
  task automatic run_calc(input string tag, input logic [65:0] prev_total, input logic [65:0] new_total);
    start = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check($sformatf("%s_finish_e%0d", tag, e), {65'd0, finish}, {65'd0, (e == 7)});
      check($sformatf("%s_busy_e%0d", tag, e), {65'd0, busy}, {65'd0, (e <= 6)});
      check($sformatf("%s_total_e%0d", tag, e), total_time, (e == 7) ? new_total : prev_total);
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    clear_inputs();
`ifdef AXIS_MASK_EN
    axis_mask = 5'b11111;
`endif
    #1;
    check("rst_finish", {65'd0, finish}, 66'd0);
    check("rst_busy", {65'd0, busy}, 66'd0);
    check("rst_total", total_time, 66'd0);
    check_max("rst", 64'd0, 64'd0, 64'd0, 64'd0);
    tick(); tick();
    reset = 1'b1;
    tick();
    check("idle_finish", {65'd0, finish}, 66'd0);

    // Basic maxima: x={10,20,30,40}, y={50,5,5,5}
    timing_x[0] = 64'd10; timing_x[1] = 64'd20; timing_x[2] = 64'd30; timing_x[3] = 64'd40;
    timing_y[0] = 64'd50; timing_y[1] = 64'd5;  timing_y[2] = 64'd5;  timing_y[3] = 64'd5;
    run_calc("basic", 66'd0, 66'd140);
    check_max("basic", 64'd50, 64'd20, 64'd30, 64'd40);

    // Hold start in DONE with larger inputs: no retrigger, no re-accumulation
    timing_z[0] = 64'd999; timing_z[1] = 64'd999; timing_z[2] = 64'd999; timing_z[3] = 64'd999;
    for (int e = 0; e < 20; e++) tick();
    check("hold_finish", {65'd0, finish}, 66'd1);
    check("hold_busy", {65'd0, busy}, 66'd0);
    check("hold_total", total_time, 66'd140);
    check_max("hold", 64'd50, 64'd20, 64'd30, 64'd40);
    start = 1'b0;
    tick();
    check("drop_finish", {65'd0, finish}, 66'd0);
    check("drop_total", total_time, 66'd140);

    // Full-scale values on e1
    clear_inputs();
    for (int k = 0; k < 4; k++) begin
      timing_x[k] = 64'd1; timing_y[k] = 64'd1; timing_z[k] = 64'd1; timing_e0[k] = 64'd1;
      timing_e1[k] = 64'hFFFF_FFFF_FFFF_FFFF;
    end
    run_calc("full", 66'd140, 66'h3_FFFF_FFFF_FFFF_FFFC);
    check_max("full", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
              64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    start = 1'b0;
    tick();

    // Abort at the third SCAN edge; previous result must persist
    clear_inputs();
    timing_x[0] = 64'd1; timing_x[1] = 64'd2; timing_x[2] = 64'd3; timing_x[3] = 64'd4;
    start = 1'b1;
    tick(); tick(); tick();
    check("abort_busy", {65'd0, busy}, 66'd1);
    start = 1'b0;
    tick();
    check("abort_finish", {65'd0, finish}, 66'd0);
    check("abort_busy_after", {65'd0, busy}, 66'd0);
    check("abort_total", total_time, 66'h3_FFFF_FFFF_FFFF_FFFC);
    check_max("abort", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
              64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    timing_x[0] = 64'd7; timing_x[1] = 64'd8; timing_x[2] = 64'd9; timing_x[3] = 64'd10;
    timing_z[0] = 64'd11; timing_z[1] = 64'd1; timing_z[2] = 64'd1; timing_z[3] = 64'd1;
    run_calc("rerun", 66'h3_FFFF_FFFF_FFFF_FFFC, 66'd38);
    check_max("rerun", 64'd11, 64'd8, 64'd9, 64'd10);
    start = 1'b0;
    tick();

    // Asynchronous reset after the second SCAN edge
    clear_inputs();
    timing_x[0] = 64'd5; timing_x[1] = 64'd6; timing_x[2] = 64'd7; timing_x[3] = 64'd8;
    start = 1'b1;
    tick(); tick(); tick();
    #2;
    reset = 1'b0;
    #1;
    check("arst_total", total_time, 66'd0);
    check("arst_busy", {65'd0, busy}, 66'd0);
    check("arst_finish", {65'd0, finish}, 66'd0);
    check_max("arst", 64'd0, 64'd0, 64'd0, 64'd0);
    tick();
    check("arst_hold_busy", {65'd0, busy}, 66'd0);
    reset = 1'b1;
    run_calc("postrst", 66'd0, 66'd26);
    check_max("postrst", 64'd5, 64'd6, 64'd7, 64'd8);
    start = 1'b0;
    tick();

    // All-zero inputs
    clear_inputs();
    run_calc("zero", 66'd26, 66'd0);
    check_max("zero", 64'd0, 64'd0, 64'd0, 64'd0);
    start = 1'b0;
    tick();

`ifdef AXIS_MASK_EN
    // Mask out x: only y contributes
    clear_inputs();
    axis_mask = 5'b11110;
    for (int k = 0; k < 4; k++) begin
      timing_x[k] = 64'd100;
      timing_y[k] = 64'(k + 1);
    end
    run_calc("mask", 66'd0, 66'd10);
    check_max("mask", 64'd1, 64'd2, 64'd3, 64'd4);
    start = 1'b0;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_max_timing.md
CALC_MAX_TIMING -- requirements
Module: calc_max_timing

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: level-held calculation enable.
REQ-004 SHALL have ports timing_x, timing_y, timing_z, timing_e0, timing_e1, each input, 64 bits x [0:3]: per-axis phase durations, unsigned, in clk ticks.
REQ-005 SHALL have port max_timing, output reg, 64 bits x [0:3]: per-phase maximum over considered axes; this port feeds the downstream per-axis parameter recalculation stage.
REQ-006 SHALL have port total_time, output reg, 66 bits: sum of max_timing[0..3].
REQ-007 SHALL have port busy, output, 1 bit: high in SCAN and SUM states.
REQ-008 SHALL have port finish, output, 1 bit: result valid; high only in DONE state.

Function
REQ-009 SHALL implement FSM states IDLE, SCAN, SUM, DONE.
REQ-010 In IDLE with start=1 at an edge: clear accumulators acc[0:3] to 0, set axis index idx=0, go to SCAN.
REQ-011 In SCAN, each edge: acc[k] = max(acc[k], timing_<axis idx>[k]) for k=0..3, axis order x,y,z,e0,e1 (idx 0..4); unsigned 64-bit compare; idx increments.
REQ-012 After processing idx=4, go to SUM; SCAN lasts exactly 5 edges.
REQ-013 In SUM, one edge: max_timing[k] <= acc[k]; total_time <= acc[0]+acc[1]+acc[2]+acc[3] zero-extended to 66 bits (no overflow possible); go to DONE.
REQ-014 finish SHALL rise after the 7th rising edge, counting the edge that samples start in IDLE as the 1st.
REQ-015 DONE holds while start=1; finish stays high, outputs stable.
REQ-016 start=0 in any state at an edge: go to IDLE, finish=0 after that edge; no further accumulation.
REQ-017 start dropped mid-SCAN or in SUM: max_timing and total_time SHALL retain last completed result (not partial accumulators).
REQ-018 Restart requires start low for at least one edge (IDLE) then high; start held high in DONE SHALL NOT retrigger.
REQ-019 timing_* inputs SHALL be required stable while busy; changes during SCAN are sampled as-is per axis, no detection.
REQ-020 Equal values: max keeps the value (tie irrelevant to output).
REQ-021 All-zero inputs: max_timing all 0, total_time 0, finish asserts normally.

Reset
REQ-022 reset=0 SHALL asynchronously force IDLE, idx=0, acc[0:3]=0, max_timing[0:3]=0, total_time=0, busy=0, finish=0.
REQ-023 reset asserted mid-operation SHALL discard the calculation; after release the block waits in IDLE for start.
REQ-024 Reset release with start=1 SHALL begin a calculation on the first edge after release.

Configuration
REQ-025 Macro AXIS_MASK_EN: when defined, add input axis_mask, 5 bits (bit0=x .. bit4=e1); axes with mask bit 0 are skipped in the max (treated as all-zero) but SCAN still takes 5 edges; axis_mask must be stable while busy.
REQ-026 AXIS_MASK_EN undefined: no axis_mask port; all five axes always considered; timing identical.

Verification
REQ-027 Reset then start=1; x={10,20,30,40}, y={50,5,5,5}, others 0 -> finish after edge 7; max_timing={50,20,30,40}; total_time=140.
REQ-028 e1={0xFFFF_FFFF_FFFF_FFFF} on all four phases, others 1 -> max_timing all 2^64-1; total_time=0x3_FFFF_FFFF_FFFF_FFFC.
REQ-029 Complete run (result R1), drop start at SCAN edge 3, re-raise with new inputs -> outputs equal R1 until the new run's SUM edge, then new result; finish low throughout abort.
REQ-030 Assert reset at SCAN edge 2 of a run -> all outputs 0 immediately (before next edge), FSM IDLE; after release with start=1 a full run completes in 7 edges.
REQ-031 start held high 20 edges after finish -> finish stays high, busy 0, no re-accumulation; start low 1 edge -> finish 0 next edge.
REQ-032 With AXIS_MASK_EN, axis_mask=5'b11110, x={100,100,100,100}, y={1,2,3,4} -> max_timing={1,2,3,4}, total_time=10.
